mips_mem_ctrl: RTL and testbench
================================

Name: mips_mem_ctrl

Overview:
Memory front-end directly downstream of the mips core. It serves the core's instruction-fetch port and its load/store data port from one word-organised backing array. Both ports have a registered one-cycle read latency. Stores are posted into a small store buffer that drains to the array in the background. Loads and fetches forward from pending buffer entries, so the core always sees coherent data.

Parameters:
MEM_WORDS, 4096, backing array depth in 32-bit words.
BASE_ADDR, 32'h0000_0000, byte address of array word 0.
SB_DEPTH, 4, store-buffer entries (power of two, >=2).

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-high; clock clk
instr_addr  in  32  core fetch byte address (core pc)
instr_rdata  out  32  fetched word, valid one cycle after instr_addr is sampled
data_addr  in  32  core load/store byte address (core alu_out)
data_wdata  in  32  core store data
data_rd_wr  in  1  1 = read, 0 = write; each cycle low is one store
data_rdata  out  32  load word, valid one cycle after data_addr is sampled
drain_hold  in  1  1 = suppress background drain (debug/test)
sb_count  out  $clog2(SB_DEPTH)+1  occupied store-buffer entries
sb_full  out  1  sb_count == SB_DEPTH
misalign_err  out  1  one-cycle pulse, addr[1:0] != 0 on a sampled data access
range_err  out  1  sticky, out-of-range access seen since reset

Behaviour:
- Reset (async): instr_rdata, data_rdata, sb_count, misalign_err and range_err go to 0; sb_full goes to 0.
  - Buffer pointers clear and pending stores are discarded.
  - Array contents are not reset.
- Word index = (addr - BASE_ADDR) >> 2. An address is in range iff BASE_ADDR <= addr and index < MEM_WORDS.
- Read, both ports, every cycle:
  - Registered output = youngest store-buffer entry with a matching index, else array[index].
  - Lookup uses pre-edge state (read-before-write): a store enqueued at the same edge is not visible.
  - A drain at the same edge does not change the result, because the entry and the array hold equal data.
- The fetch port uses the same forwarding, so self-modifying stores are coherent.
- Store (data_rd_wr=0, in range, aligned): enqueued at the tail as {index, data_wdata}.
  - Exactly one store is enqueued per cycle low.
- Drain: when the buffer is non-empty and drain_hold=0, the head is written to the array and popped.
  - At most one drain per cycle.
  - Simultaneous enqueue and drain leaves sb_count unchanged.
- Full: a store arriving while sb_count==SB_DEPTH forces a head drain that cycle, even with drain_hold=1.
  - The new store is accepted; no store is ever dropped.
- Misaligned data access:
  - Read returns the word at the aligned index.
  - Write is dropped.
  - misalign_err=1 for exactly one cycle.
  - Fetch port ignores addr[1:0].
- Out of range, either port:
  - Read returns 32'h0.
  - Write is dropped.
  - range_err is set and held until reset.
- Pointer wrap: head and tail are modulo SB_DEPTH. Full and empty are distinguished by the count, not by pointer equality.
- Reset mid-drain: the in-flight array write does not complete. Reset wins.

Decomposition:
- Package mips_mem_pkg:
  - word_t (logic [31:0]), idx_t.
  - sb_entry_t {idx_t idx; word_t data;}.
  - Constants RD = 1'b1 and WR = 1'b0.
  - Function word_index(addr, base).
  - Function in_range(addr, base, words).
- Sub-module mips_store_buffer:
  - FIFO of sb_entry_t.
  - Enqueue/drain/forced-drain control.
  - Two combinational youngest-match lookup ports.
- Top-level mips_mem_ctrl holds:
  - The array.
  - Address decode and error flags.
  - The output registers.

Test Plan:
- Preload array[3]=32'h1111; hold data_addr=0xC read -> data_rdata=32'h1111 on the next edge; instr_addr=0xC gives the same on instr_rdata.
- drain_hold=1; store 0xAAAA to 0x10, then read 0x10 -> data_rdata=0xAAAA from forwarding; sb_count=1; array[4] still old.
- drain_hold=1; store 0x1,0x2,0x3,0x4 to 0x20 -> sb_full=1.
  - Fifth store 0x5 to 0x24 -> sb_count stays 4 and array[8]=0x1.
  - Read 0x20 -> 0x4, the youngest match.
- Same-edge store 0xBEEF and read at 0x30 -> data_rdata=old value; next-cycle read -> 0xBEEF.
- Store to 0x31 -> misalign_err pulses one cycle and sb_count is unchanged; read 0x31 -> word at 0x30.
- Read at BASE_ADDR+4*MEM_WORDS -> data_rdata=0 and range_err=1 stays high; assert reset with 2 entries pending -> sb_count=0 and range_err=0 immediately.

Source files
------------

// File: rtl/mips_mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mips_mem_pkg
//  Brief    : Shared types, constants and address helpers for the mips
//             memory front-end (array + store buffer).
//  Revision : 1.0  initial release
// ============================================================================
package mips_mem_pkg;

  // Word index width: a 32-bit byte address carries 30 bits of word index.
  localparam int IDX_W = 30;

  typedef logic [31:0]      word_t;
  typedef logic [IDX_W-1:0] idx_t;

  typedef struct packed {
    idx_t  idx;
    word_t data;
  } sb_entry_t;

  // Encoding of the core's data_rd_wr strobe.
  localparam logic RD = 1'b1;
  localparam logic WR = 1'b0;

  // Word index of a byte address relative to the array base; the low two
  // address bits are discarded, so a misaligned address maps to its
  // containing word.
  function automatic idx_t word_index(input word_t addr, input word_t base);
    return idx_t'((addr - base) >> 2);
  endfunction

  // True when the address lies inside the backing array.
  function automatic logic in_range(input word_t addr, input word_t base,
                                    input int unsigned words);
    idx_t idx;
    idx = word_index(addr, base);
    return (addr >= base) && ({2'b00, idx} < words);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mips_store_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : mips_store_buffer
//  Brief    : Posted-store FIFO with background drain, forced drain when
//             full, and two youngest-match forwarding lookup ports.
//  Revision : 1.0  initial release
// ============================================================================
module mips_store_buffer
  import mips_mem_pkg::*;
#(
  parameter int SB_DEPTH = 4,
  localparam int PW = $clog2(SB_DEPTH),
  localparam int CW = PW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enq_i,
  input  logic [IDX_W-1:0] enq_idx_i,
  input  logic [31:0]      enq_data_i,
  input  logic             hold_i,
  output logic             drain_o,
  output logic [IDX_W-1:0] drain_idx_o,
  output logic [31:0]      drain_data_o,
  output logic [CW-1:0]    count_o,
  output logic             full_o,
  input  logic [IDX_W-1:0] lk0_idx_i,
  output logic             lk0_hit_o,
  output logic [31:0]      lk0_data_o,
  input  logic [IDX_W-1:0] lk1_idx_i,
  output logic             lk1_hit_o,
  output logic [31:0]      lk1_data_o
);

  sb_entry_t         entries_q [SB_DEPTH];
  logic [PW-1:0]     head_q, head_d;
  logic [PW-1:0]     tail_q, tail_d;
  logic [CW-1:0]     count_q, count_d;
  logic              w_full;
  logic              w_empty;
  logic              w_drain;

  // Full/empty come from the count; head==tail is ambiguous after a wrap.
  assign w_full  = (count_q == CW'(SB_DEPTH));
  assign w_empty = (count_q == '0);
  // A store arriving while full forces a drain so it is never dropped.
  assign w_drain = !w_empty && (!hold_i || (w_full && enq_i));

  assign drain_o      = w_drain;
  assign drain_idx_o  = entries_q[head_q].idx;
  assign drain_data_o = entries_q[head_q].data;
  assign count_o      = count_q;
  assign full_o       = w_full;

  // Youngest valid entry whose index matches; later (younger) hits override.
  function automatic logic [32:0] lookup(input logic [IDX_W-1:0] idx);
    logic [PW-1:0] pos;
    logic [32:0]   res;
    res = '0;
    for (int i = 0; i < SB_DEPTH; i++) begin
      pos = head_q + PW'(i);
      if ((CW'(i) < count_q) && (entries_q[pos].idx == idx)) begin
        res = {1'b1, entries_q[pos].data};
      end
    end
    return res;
  endfunction

  // Forwarding lookups for the data and fetch ports.
  always_comb begin
    {lk0_hit_o, lk0_data_o} = lookup(lk0_idx_i);
    {lk1_hit_o, lk1_data_o} = lookup(lk1_idx_i);
  end

  // Next pointer/count; enqueue and drain together leave the count unchanged.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (enq_i)   tail_d = tail_q + PW'(1);
    if (w_drain) head_d = head_q + PW'(1);
    case ({enq_i, w_drain})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer/count state; reset discards all pending stores.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry payload storage; validity is tracked by the pointers alone.
  always_ff @(posedge clk) begin
    if (enq_i) entries_q[tail_q] <= '{idx: enq_idx_i, data: enq_data_i};
  end

endmodule
`default_nettype wire

// File: rtl/mips_mem_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : mips_mem_ctrl
//  Brief    : Memory front-end for the mips core: fetch and load/store ports
//             on one word array, posted stores with coherent forwarding.
//  Revision : 1.0  initial release
// ============================================================================
module mips_mem_ctrl
  import mips_mem_pkg::*;
#(
  parameter int          MEM_WORDS = 4096,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          SB_DEPTH  = 4,
  localparam int         CW        = $clog2(SB_DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [31:0]   instr_addr,
  output logic [31:0]   instr_rdata,
  input  logic [31:0]   data_addr,
  input  logic [31:0]   data_wdata,
  input  logic          data_rd_wr,
  output logic [31:0]   data_rdata,
  input  logic          drain_hold,
  output logic [CW-1:0] sb_count,
  output logic          sb_full,
  output logic          misalign_err,
  output logic          range_err
);

  localparam int AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

  logic [31:0]      mem_q [MEM_WORDS];

  logic [IDX_W-1:0] w_d_idx, w_i_idx;
  logic             w_d_inr, w_i_inr;
  logic             w_misalign;
  logic             w_enq;
  logic             w_drain;
  logic [IDX_W-1:0] w_drain_idx;
  logic [31:0]      w_drain_data;
  logic             w_d_hit, w_i_hit;
  logic [31:0]      w_d_fwd, w_i_fwd;

  logic [31:0]      data_rdata_q, data_rdata_d;
  logic [31:0]      instr_rdata_q, instr_rdata_d;
  logic             misalign_q, range_q, range_d;

  assign w_d_idx    = word_index(data_addr, BASE_ADDR);
  assign w_i_idx    = word_index(instr_addr, BASE_ADDR);
  assign w_d_inr    = in_range(data_addr, BASE_ADDR, MEM_WORDS);
  assign w_i_inr    = in_range(instr_addr, BASE_ADDR, MEM_WORDS);
  assign w_misalign = (data_addr[1:0] != 2'b00);
  assign w_enq      = (data_rd_wr == WR) && w_d_inr && !w_misalign;

  mips_store_buffer #(.SB_DEPTH(SB_DEPTH)) u_sb (
    .clk          (clk),
    .reset        (reset),
    .enq_i        (w_enq),
    .enq_idx_i    (w_d_idx),
    .enq_data_i   (data_wdata),
    .hold_i       (drain_hold),
    .drain_o      (w_drain),
    .drain_idx_o  (w_drain_idx),
    .drain_data_o (w_drain_data),
    .count_o      (sb_count),
    .full_o       (sb_full),
    .lk0_idx_i    (w_d_idx),
    .lk0_hit_o    (w_d_hit),
    .lk0_data_o   (w_d_fwd),
    .lk1_idx_i    (w_i_idx),
    .lk1_hit_o    (w_i_hit),
    .lk1_data_o   (w_i_fwd)
  );

  // Read selection from pre-edge state: buffer hit first, else array, 0 if out of range.
  always_comb begin
    data_rdata_d  = '0;
    instr_rdata_d = '0;
    if (w_d_inr) data_rdata_d  = w_d_hit ? w_d_fwd : mem_q[w_d_idx[AW-1:0]];
    if (w_i_inr) instr_rdata_d = w_i_hit ? w_i_fwd : mem_q[w_i_idx[AW-1:0]];
    range_d = range_q | !w_d_inr | !w_i_inr;
  end

  // Output registers and error flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_rdata_q  <= '0;
      instr_rdata_q <= '0;
      misalign_q    <= 1'b0;
      range_q       <= 1'b0;
    end else begin
      data_rdata_q  <= data_rdata_d;
      instr_rdata_q <= instr_rdata_d;
      misalign_q    <= w_misalign;
      range_q       <= range_d;
    end
  end

  // Background drain into the array; the count clears asynchronously on
  // reset, so no drain is issued while reset is held.
  always_ff @(posedge clk) begin
    if (w_drain && ({2'b00, w_drain_idx} < 32'(MEM_WORDS)))
      mem_q[w_drain_idx[AW-1:0]] <= w_drain_data;
  end

  assign data_rdata   = data_rdata_q;
  assign instr_rdata  = instr_rdata_q;
  assign misalign_err = misalign_q;
  assign range_err    = range_q;

endmodule
`default_nettype wire

// File: tb/tb_mips_mem_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mips_mem_ctrl
//  Brief    : Self-checking bench for mips_mem_ctrl with a read scoreboard.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mips_mem_ctrl;
  import mips_mem_pkg::*;

  localparam int MEM_WORDS = 4096;
  localparam int SB_DEPTH  = 4;
  localparam int CW        = $clog2(SB_DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [31:0]   instr_addr = '0;
  logic [31:0]   instr_rdata;
  logic [31:0]   data_addr = '0;
  logic [31:0]   data_wdata = '0;
  logic          data_rd_wr = RD;
  logic [31:0]   data_rdata;
  logic          drain_hold = 1'b0;
  logic [CW-1:0] sb_count;
  logic          sb_full;
  logic          misalign_err;
  logic          range_err;

  int n_cmp = 0;
  int n_err = 0;

  // Scoreboard: port select (0 data, 1 fetch), expected word, tag.
  int          q_sel [$];
  logic [31:0] q_val [$];
  string       q_tag [$];

  mips_mem_ctrl #(
    .MEM_WORDS (MEM_WORDS),
    .BASE_ADDR (32'h0000_0000),
    .SB_DEPTH  (SB_DEPTH)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .instr_addr   (instr_addr),
    .instr_rdata  (instr_rdata),
    .data_addr    (data_addr),
    .data_wdata   (data_wdata),
    .data_rd_wr   (data_rd_wr),
    .data_rdata   (data_rdata),
    .drain_hold   (drain_hold),
    .sb_count     (sb_count),
    .sb_full      (sb_full),
    .misalign_err (misalign_err),
    .range_err    (range_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One cycle: drive at a negedge, push read expectations, step one edge,
  // then pop and compare everything the edge produced.
  task automatic xfer(input logic [31:0] daddr, input logic [31:0] wd, input logic rw,
                      input logic chk_d, input logic [31:0] ed,
                      input logic [31:0] iaddr, input logic chk_i, input logic [31:0] ei,
                      input string tag);
    int          sel;
    logic [31:0] ev;
    string       t;
    data_addr  = daddr;
    data_wdata = wd;
    data_rd_wr = rw;
    instr_addr = iaddr;
    if (chk_d) begin q_sel.push_back(0); q_val.push_back(ed); q_tag.push_back({tag, "/d"}); end
    if (chk_i) begin q_sel.push_back(1); q_val.push_back(ei); q_tag.push_back({tag, "/i"}); end
    @(negedge clk);
    data_rd_wr = RD;
    while (q_val.size() > 0) begin
      sel = q_sel.pop_front();
      ev  = q_val.pop_front();
      t   = q_tag.pop_front();
      chk(t, (sel == 0) ? data_rdata : instr_rdata, ev);
    end
  endtask

  task automatic st(input logic [31:0] a, input logic [31:0] d);
    xfer(a, d, WR, 1'b0, '0, 32'h0, 1'b0, '0, "st");
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) xfer(32'h0, '0, RD, 1'b0, '0, 32'h0, 1'b0, '0, "idle");
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #1 reset = 1'b1;
    #2;
    chk("rst_count",  32'(sb_count), 32'd0);
    chk("rst_full",   32'(sb_full), 32'd0);
    chk("rst_drdata", data_rdata, 32'h0);
    chk("rst_irdata", instr_rdata, 32'h0);
    chk("rst_errs",   32'({misalign_err, range_err}), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Preload through the buffer with drain enabled
    drain_hold = 1'b0;
    st(32'h0C, 32'h1111);
    st(32'h10, 32'h4444);
    st(32'h30, 32'h3030);
    st(32'h50, 32'h5050);
    idle(3);
    chk("preload_drained", 32'(sb_count), 32'd0);
    xfer(32'h0C, '0, RD, 1'b1, 32'h1111, 32'h0C, 1'b1, 32'h1111, "rd_array");

    // Forwarding from a held entry
    drain_hold = 1'b1;
    xfer(32'h10, 32'hAAAA, WR, 1'b1, 32'h4444, 32'h0, 1'b0, '0, "st_rbw");
    xfer(32'h10, '0, RD, 1'b1, 32'hAAAA, 32'h10, 1'b1, 32'hAAAA, "rd_fwd");
    chk("fwd_count", 32'(sb_count), 32'd1);
    chk("fwd_array_old", dut.mem_q[4], 32'h4444);
    drain_hold = 1'b0;
    idle(1);
    chk("fwd_drained", 32'(sb_count), 32'd0);
    chk("fwd_array_new", dut.mem_q[4], 32'hAAAA);

    // Fill, forced drain on full, youngest match
    drain_hold = 1'b1;
    for (int k = 1; k <= 4; k++) st(32'h20, 32'(k));
    chk("full_count", 32'(sb_count), 32'd4);
    chk("full_flag",  32'(sb_full), 32'd1);
    st(32'h24, 32'h5);
    chk("forced_count", 32'(sb_count), 32'd4);
    chk("forced_array", dut.mem_q[8], 32'h1);
    xfer(32'h20, '0, RD, 1'b1, 32'h4, 32'h24, 1'b1, 32'h5, "youngest");
    drain_hold = 1'b0;
    idle(4);
    chk("wrap_drained", 32'(sb_count), 32'd0);
    xfer(32'h20, '0, RD, 1'b1, 32'h4, 32'h24, 1'b1, 32'h5, "wrap_array");

    // Same-edge store/read is read-before-write
    xfer(32'h30, 32'hBEEF, WR, 1'b1, 32'h3030, 32'h0, 1'b0, '0, "same_edge");
    xfer(32'h30, '0, RD, 1'b1, 32'hBEEF, 32'h0, 1'b0, '0, "next_cycle");

    // Misaligned accesses
    drain_hold = 1'b1;
    idle(1);
    xfer(32'h31, 32'h5555, WR, 1'b1, 32'hBEEF, 32'h0, 1'b0, '0, "mis_st");
    chk("mis_pulse", 32'(misalign_err), 32'd1);
    chk("mis_dropped", 32'(sb_count), 32'd0);
    xfer(32'h30, '0, RD, 1'b1, 32'hBEEF, 32'h0, 1'b0, '0, "mis_after");
    chk("mis_clear", 32'(misalign_err), 32'd0);
    xfer(32'h31, '0, RD, 1'b1, 32'hBEEF, 32'h33, 1'b1, 32'hBEEF, "mis_rd");
    chk("mis_rd_pulse", 32'(misalign_err), 32'd1);
    chk("no_range_yet", 32'(range_err), 32'd0);

    // Out of range on both ports
    xfer(32'(4 * MEM_WORDS), '0, RD, 1'b1, 32'h0, 32'(4 * MEM_WORDS), 1'b1, 32'h0, "oor_rd");
    chk("range_set", 32'(range_err), 32'd1);
    xfer(32'(4 * MEM_WORDS + 4), 32'h9999, WR, 1'b1, 32'h0, 32'h0, 1'b0, '0, "oor_st");
    chk("oor_dropped", 32'(sb_count), 32'd0);
    xfer(32'h0C, '0, RD, 1'b1, 32'h1111, 32'h0, 1'b0, '0, "after_oor");
    chk("range_sticky", 32'(range_err), 32'd1);

    // Asynchronous reset with pending stores
    st(32'h50, 32'h7777);
    st(32'h54, 32'h8888);
    chk("pend_count", 32'(sb_count), 32'd2);
    #2 reset = 1'b1;
    #1;
    chk("arst_count", 32'(sb_count), 32'd0);
    chk("arst_range", 32'(range_err), 32'd0);
    chk("arst_drdata", data_rdata, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    drain_hold = 1'b0;
    xfer(32'h50, '0, RD, 1'b1, 32'h5050, 32'h0C, 1'b1, 32'h1111, "discarded");
    idle(1);
    chk("post_rst_count", 32'(sb_count), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
